// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath: sequencer state encoding and the
// dimension/address-width legality check used by the sequencer and the buffer/RAM wrappers.
package mm_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      WRITE = ST_WRITE,
      DONE  = ST_DONE
   } mm_state_t;

   // True when a DIM x DIM matrix fits an address space of aw bits.
   function automatic bit mm_dims_ok(input int dim, input int aw);
      return (dim >= 2) && (dim * dim <= (1 << aw));
   endfunction

endpackage

// File: rtl/mm_index_counter.sv
// Nested k/j/i counters for the sequencer, with last-flags and running A/B address bases
// (a_base steps by DIM per row, b pointer steps by DIM per k), so no multipliers are needed.
module mm_index_counter #(
   parameter int DIM = 2,
   parameter int M   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         step_k,
   input  logic         step_j,
   output logic         k_last,
   output logic         all_last,
   output logic [M-1:0] a_adr,
   output logic [M-1:0] b_adr
);
   localparam logic [M-1:0] LAST   = M'(DIM - 1);
   localparam logic [M-1:0] STRIDE = M'(DIM);

   logic [M-1:0] k_reg, j_reg, i_reg;
   logic [M-1:0] a_base_reg, a_ptr_reg, b_ptr_reg;
   logic         j_last, i_last;

   assign k_last   = (k_reg == LAST);
   assign j_last   = (j_reg == LAST);
   assign i_last   = (i_reg == LAST);
   assign all_last = i_last && j_last;
   assign a_adr    = a_ptr_reg;
   assign b_adr    = b_ptr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_reg      <= '0;
         j_reg      <= '0;
         i_reg      <= '0;
         a_base_reg <= '0;
         a_ptr_reg  <= '0;
         b_ptr_reg  <= '0;
      end else if (clr) begin
         k_reg      <= '0;
         j_reg      <= '0;
         i_reg      <= '0;
         a_base_reg <= '0;
         a_ptr_reg  <= '0;
         b_ptr_reg  <= '0;
      end else if (step_k) begin
         if (k_last) begin
            k_reg <= '0;
         end else begin
            k_reg     <= k_reg + 1'b1;
            a_ptr_reg <= a_ptr_reg + 1'b1;
            b_ptr_reg <= b_ptr_reg + STRIDE;
         end
      end else if (step_j) begin
         // Pointers are rebuilt for k=0 of the next element: A at the row base, B at column j.
         if (j_last) begin
            j_reg     <= '0;
            b_ptr_reg <= '0;
            if (i_last) begin
               i_reg      <= '0;
               a_base_reg <= '0;
               a_ptr_reg  <= '0;
            end else begin
               i_reg      <= i_reg + 1'b1;
               a_base_reg <= a_base_reg + STRIDE;
               a_ptr_reg  <= a_base_reg + STRIDE;
            end
         end else begin
            j_reg     <= j_reg + 1'b1;
            a_ptr_reg <= a_base_reg;
            b_ptr_reg <= j_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM for the square matrix multiply: walks A/B, drives MAC clear/enable, strobes each
// finished C element into the append-only result RAM, and handles the host start/done handshake.
module matmul_sequencer
   import mm_pkg::*;
#(
   parameter int DIM = 2,
   parameter int M   = 4,
   parameter int RM  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   output logic         a_rd,
   output logic [M-1:0] a_adr,
   output logic         b_rd,
   output logic [M-1:0] b_adr,
   output logic         mac_en,
   output logic         mac_clr,
   output logic         res_wr,
   output logic         busy,
   output logic         done
);
   if (!mm_dims_ok(DIM, M)) begin : g_bad_m
      $error("matmul_sequencer: DIM*DIM exceeds operand address space 2**M");
   end
   if (!mm_dims_ok(DIM, RM)) begin : g_bad_rm
      $error("matmul_sequencer: DIM*DIM exceeds result RAM address space 2**RM");
   end

   mm_state_t state_reg;
   logic      rd_reg, mac_en_reg, mac_clr_reg, res_wr_reg, busy_reg, done_reg;
   logic      k_last, all_last, cnt_clr, step_k, step_j;

   assign cnt_clr = abort && (state_reg != IDLE);
   assign step_k  = (state_reg == RUN);
   assign step_j  = (state_reg == WRITE);

   mm_index_counter #(.DIM(DIM), .M(M)) u_idx (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .step_k   (step_k),
      .step_j   (step_j),
      .k_last   (k_last),
      .all_last (all_last),
      .a_adr    (a_adr),
      .b_adr    (b_adr)
   );

   // Outputs are registered alongside the state so they always describe the current state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         rd_reg      <= 1'b0;
         mac_en_reg  <= 1'b0;
         mac_clr_reg <= 1'b0;
         res_wr_reg  <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         rd_reg      <= 1'b0;
         mac_en_reg  <= 1'b0;
         mac_clr_reg <= 1'b0;
         res_wr_reg  <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start && !abort) begin
                  state_reg   <= RUN;
                  rd_reg      <= 1'b1;
                  mac_en_reg  <= 1'b1;
                  mac_clr_reg <= 1'b1;
                  busy_reg    <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  state_reg <= IDLE;
               end else if (k_last) begin
                  state_reg  <= WRITE;
                  res_wr_reg <= 1'b1;
                  busy_reg   <= 1'b1;
               end else begin
                  rd_reg     <= 1'b1;
                  mac_en_reg <= 1'b1;
                  busy_reg   <= 1'b1;
               end
            end
            WRITE: begin
               if (abort) begin
                  state_reg <= IDLE;
               end else if (all_last) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg   <= RUN;
                  rd_reg      <= 1'b1;
                  mac_en_reg  <= 1'b1;
                  mac_clr_reg <= 1'b1;
                  busy_reg    <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign a_rd    = rd_reg;
   assign b_rd    = rd_reg;
   assign mac_en  = mac_en_reg;
   assign mac_clr = mac_clr_reg;
   assign res_wr  = res_wr_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: DIM=2 and DIM=3 instances driving bench-side operand
// buffers, a MAC and an append-only result RAM.
module tb_matmul_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- DIM=2 instance and datapath ----------------
   logic       start2 = 1'b0, abort2 = 1'b0;
   logic       a_rd2, b_rd2, mac_en2, mac_clr2, res_wr2, busy2, done2;
   logic [3:0] a_adr2, b_adr2;
   logic [7:0] a2 [16];
   logic [7:0] b2 [16];
   logic [15:0] acc2, prod2;
   logic [15:0] ram2 [16];
   logic [3:0]  top2;

   matmul_sequencer #(.DIM(2), .M(4), .RM(4)) dut (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2),
      .a_rd(a_rd2), .a_adr(a_adr2), .b_rd(b_rd2), .b_adr(b_adr2),
      .mac_en(mac_en2), .mac_clr(mac_clr2), .res_wr(res_wr2),
      .busy(busy2), .done(done2)
   );

   assign prod2 = 16'(a_rd2 ? a2[a_adr2] : 8'd0) * 16'(b_rd2 ? b2[b_adr2] : 8'd0);

   always @(posedge clk or posedge rst) begin
      if (rst) top2 <= '0;
      else begin
         if (mac_en2) acc2 <= mac_clr2 ? prod2 : acc2 + prod2;
         if (res_wr2) begin
            ram2[top2] <= acc2;
            top2 <= top2 + 1'b1;
         end
      end
   end

   // ---------------- DIM=3 instance and datapath ----------------
   logic       start3 = 1'b0, abort3 = 1'b0;
   logic       a_rd3, b_rd3, mac_en3, mac_clr3, res_wr3, busy3, done3;
   logic [3:0] a_adr3, b_adr3;
   logic [7:0] a3 [16];
   logic [7:0] b3 [16];
   logic [15:0] acc3, prod3;
   logic [15:0] ram3 [16];
   logic [3:0]  top3;

   matmul_sequencer #(.DIM(3), .M(4), .RM(4)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3),
      .a_rd(a_rd3), .a_adr(a_adr3), .b_rd(b_rd3), .b_adr(b_adr3),
      .mac_en(mac_en3), .mac_clr(mac_clr3), .res_wr(res_wr3),
      .busy(busy3), .done(done3)
   );

   assign prod3 = 16'(a_rd3 ? a3[a_adr3] : 8'd0) * 16'(b_rd3 ? b3[b_adr3] : 8'd0);

   always @(posedge clk or posedge rst) begin
      if (rst) top3 <= '0;
      else begin
         if (mac_en3) acc3 <= mac_clr3 ? prod3 : acc3 + prod3;
         if (res_wr3) begin
            ram3[top3] <= acc3;
            top3 <= top3 + 1'b1;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] ctl2();
      return {a_rd2, b_rd2, mac_en2, mac_clr2, res_wr2, busy2, done2};
   endfunction

   // control word order: a_rd b_rd mac_en mac_clr res_wr busy done
   localparam logic [6:0] C_RUN0  = 7'b1111010;
   localparam logic [6:0] C_RUN1  = 7'b1110010;
   localparam logic [6:0] C_WRITE = 7'b0000110;
   localparam logic [6:0] C_DONE  = 7'b0000001;
   localparam logic [6:0] C_IDLE  = 7'b0000000;

   initial begin
      int exp_a [8];
      int exp_b [8];
      int wr_cnt, done_cnt, done_at, busy_cnt, mc;
      logic [6:0] ec;
      exp_a = '{0, 1, 0, 1, 2, 3, 2, 3};
      exp_b = '{0, 2, 1, 3, 0, 2, 1, 3};

      for (int i = 0; i < 16; i++) begin
         a2[i] = 8'd0; b2[i] = 8'd0; a3[i] = 8'd0; b3[i] = 8'd0;
      end
      a2[0] = 8'd1; a2[1] = 8'd2; a2[2] = 8'd3; a2[3] = 8'd4;
      b2[0] = 8'd5; b2[1] = 8'd6; b2[2] = 8'd7; b2[3] = 8'd8;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_ctl", 32'(ctl2()), 32'(C_IDLE));
      chk("reset_a_adr", 32'(a_adr2), 0);
      chk("reset_b_adr", 32'(b_adr2), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ctl", 32'(ctl2()), 32'(C_IDLE));

      // Job 1: full trace, A=[1 2;3 4] B=[5 6;7 8]
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      wr_cnt = 0; done_cnt = 0; done_at = 0;
      for (int n = 1; n <= 13; n++) begin
         if (n == 13) ec = C_DONE;
         else if ((n - 1) % 3 == 0) ec = C_RUN0;
         else if ((n - 1) % 3 == 1) ec = C_RUN1;
         else ec = C_WRITE;
         chk($sformatf("job1_ctl_c%0d", n), 32'(ctl2()), 32'(ec));
         if (n < 13 && (n - 1) % 3 != 2) begin
            chk($sformatf("job1_a_adr_c%0d", n), 32'(a_adr2), 32'(exp_a[((n - 1) / 3) * 2 + (n - 1) % 3]));
            chk($sformatf("job1_b_adr_c%0d", n), 32'(b_adr2), 32'(exp_b[((n - 1) / 3) * 2 + (n - 1) % 3]));
         end
         if (done2) begin done_cnt++; done_at = n; end
         @(negedge clk);
      end
      chk("job1_after_ctl", 32'(ctl2()), 32'(C_IDLE));
      chk("job1_done_cnt", done_cnt, 1);
      chk("job1_done_at", done_at, 13);
      chk("job1_ram0", 32'(ram2[0]), 19);
      chk("job1_ram1", 32'(ram2[1]), 22);
      chk("job1_ram2", 32'(ram2[2]), 43);
      chk("job1_ram3", 32'(ram2[3]), 50);
      chk("job1_top", 32'(top2), 4);

      // Job 2: start held high through the run -> exactly one job
      start2 = 1'b1;
      @(negedge clk);
      wr_cnt = 0; done_cnt = 0; done_at = 0;
      for (int n = 1; n <= 13; n++) begin
         if (res_wr2) wr_cnt++;
         if (done2) begin done_cnt++; done_at = n; end
         if (n == 13) start2 = 1'b0;
         @(negedge clk);
      end
      busy_cnt = 0;
      for (int n = 0; n < 5; n++) begin
         if (busy2 || res_wr2 || done2) busy_cnt++;
         @(negedge clk);
      end
      chk("held_wr_cnt", wr_cnt, 4);
      chk("held_done_at", done_at, 13);
      chk("held_done_cnt", done_cnt, 1);
      chk("held_no_second_job", busy_cnt, 0);
      chk("held_top", 32'(top2), 8);
      chk("held_ram4", 32'(ram2[4]), 19);
      chk("held_ram7", 32'(ram2[7]), 50);

      // abort has priority over start in IDLE
      start2 = 1'b1; abort2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0; abort2 = 1'b0;
      chk("idle_abort_prio", 32'(ctl2()), 32'(C_IDLE));

      // Abort during the second element's RUN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_top_reset", 32'(top2), 0);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_pre_ctl", 32'(ctl2()), 32'(C_RUN0));
      abort2 = 1'b1;
      @(negedge clk);
      abort2 = 1'b0;
      chk("abort_ctl", 32'(ctl2()), 32'(C_IDLE));
      chk("abort_a_adr", 32'(a_adr2), 0);
      chk("abort_b_adr", 32'(b_adr2), 0);
      chk("abort_top", 32'(top2), 1);
      chk("abort_ram0", 32'(ram2[0]), 19);
      busy_cnt = 0;
      for (int n = 0; n < 15; n++) begin
         if (busy2 || res_wr2 || done2) busy_cnt++;
         @(negedge clk);
      end
      chk("abort_quiet", busy_cnt, 0);

      // Async reset mid-RUN, then a fresh job with B=2*I -> C=2*A
      b2[0] = 8'd2; b2[1] = 8'd0; b2[2] = 8'd0; b2[3] = 8'd2;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      @(negedge clk);
      chk("rst_pre_ctl", 32'(ctl2()), 32'(C_RUN1));
      #2 rst = 1'b1;
      #1;
      chk("rst_async_ctl", 32'(ctl2()), 32'(C_IDLE));
      chk("rst_async_a_adr", 32'(a_adr2), 0);
      chk("rst_async_b_adr", 32'(b_adr2), 0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_top", 32'(top2), 0);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      repeat (13) @(negedge clk);
      chk("rst_job_ram0", 32'(ram2[0]), 2);
      chk("rst_job_ram1", 32'(ram2[1]), 4);
      chk("rst_job_ram2", 32'(ram2[2]), 6);
      chk("rst_job_ram3", 32'(ram2[3]), 8);
      chk("rst_job_top", 32'(top2), 4);

      // DIM=3: identity A, random B -> C == B
      a3[0] = 8'd1; a3[4] = 8'd1; a3[8] = 8'd1;
      for (int i = 0; i < 9; i++) b3[i] = 8'($urandom_range(0, 15));
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      wr_cnt = 0; done_cnt = 0; done_at = 0; mc = 0;
      for (int n = 1; n <= 40; n++) begin
         if (mac_en3) mc++;
         if (res_wr3) begin
            chk($sformatf("d3_mac_before_wr%0d", wr_cnt), mc, 3);
            mc = 0;
            wr_cnt++;
         end
         if (done3) begin done_cnt++; done_at = n; end
         @(negedge clk);
      end
      chk("d3_wr_cnt", wr_cnt, 9);
      chk("d3_done_cnt", done_cnt, 1);
      chk("d3_done_at", done_at, 37);
      chk("d3_top", 32'(top3), 9);
      for (int i = 0; i < 9; i++)
         chk($sformatf("d3_ram%0d", i), 32'(ram3[i]), 32'(b3[i]));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
